// File: rtl/pong_video_pkg.sv
// Default 640x480@60 raster timing and the coordinate-width check
// shared by the video timing blocks.
package pong_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CW       = 10;
    localparam int DEF_FW       = 8;

    // True when a counter of width cw can hold every value 0..total-1.
    function automatic bit cw_fits(input int cw, input int total);
        return (total <= 1) || ($clog2(total) <= cw);
    endfunction

endpackage

// File: rtl/pix_en_gen.sv
// Pixel clock-enable: one system clock in every CLK_DIV, taken
// combinationally from a free-running divider count.
module pix_en_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_en_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) div_q <= '0;
        else         div_q <= div_d;
    end

    // With CLK_DIV=1 the count is stuck at 0 == LAST, so the enable is always high.
    assign pix_en_o = (div_q == LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: x/y/frame counters stepped by the
// pixel enable, with all decoded outputs registered one pixel slot behind.
module video_timing_gen
    import pong_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CW       = DEF_CW,
    parameter int FW       = DEF_FW
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] xpos,
    output logic [CW-1:0] ypos,
    output logic          sof,
    output logic          vblank,
    output logic          eol,
    output logic [FW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (!cw_fits(CW, H_TOTAL) || !cw_fits(CW, V_TOTAL)) begin : g_cw_err
        $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    // Window bounds carry one extra bit so an edge equal to 2**CW stays exact.
    typedef logic [CW:0] cwx_t;
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam cwx_t          H_ACT_X  = cwx_t'(H_ACTIVE);
    localparam cwx_t          V_ACT_X  = cwx_t'(V_ACTIVE);
    localparam cwx_t          HS_START = cwx_t'(H_ACTIVE + H_FP);
    localparam cwx_t          HS_END   = cwx_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cwx_t          VS_START = cwx_t'(V_ACTIVE + V_FP);
    localparam cwx_t          VS_END   = cwx_t'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [CW-1:0] xpos_q, ypos_q;
    logic          hsync_q, vsync_q, de_q, sof_q, vblank_q, eol_q;
    logic          x_wrap, y_wrap, hs_act, vs_act;
    cwx_t          x_x, y_x;

    pix_en_gen #(.CLK_DIV(CLK_DIV)) u_pix_en (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .pix_en_o (pix_en)
    );

    always_comb begin
        x_wrap  = (x_q == H_LAST);
        y_wrap  = (y_q == V_LAST);
        x_d     = x_wrap ? '0 : x_q + CW'(1);
        y_d     = x_wrap ? (y_wrap ? '0 : y_q + CW'(1)) : y_q;
        frame_d = (x_wrap && y_wrap) ? frame_q + FW'(1) : frame_q;
        x_x     = {1'b0, x_q};
        y_x     = {1'b0, y_q};
        hs_act  = (x_x >= HS_START) && (x_x < HS_END);
        vs_act  = (y_x >= VS_START) && (y_x < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            frame_q  <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            de_q     <= 1'b0;
            sof_q    <= 1'b0;
            vblank_q <= 1'b0;
            eol_q    <= 1'b0;
        end else if (pix_en) begin
            x_q      <= x_d;
            y_q      <= y_d;
            frame_q  <= frame_d;
            xpos_q   <= x_q;
            ypos_q   <= y_q;
            hsync_q  <= hs_act ? HS_POL : ~HS_POL;
            vsync_q  <= vs_act ? VS_POL : ~VS_POL;
            de_q     <= (x_x < H_ACT_X) && (y_x < V_ACT_X);
            sof_q    <= (x_q == '0) && (y_q == '0);
            vblank_q <= (x_q == '0) && (y_x == V_ACT_X);
            eol_q    <= x_wrap;
        end
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign sof       = sof_q;
    assign vblank    = vblank_q;
    assign eol       = eol_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three modes under a closed-form raster model,
// a decode table for the small mode, and timed sequences for sync/reset corners.
module tb_video_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, dv, fw;
    } cfg_t;

    typedef struct packed {
        logic        pix_en, hsync, vsync, de, sof, vblank, eol;
        logic [15:0] x, y;
        logic [7:0]  frame;
    } out_t;

    typedef struct {
        int x, y;
        logic [5:0] exp; // {hsync, vsync, de, sof, vblank, eol}
    } vec_t;

    localparam cfg_t C0 = '{640, 16, 96, 48, 6, 2, 2, 2, 0, 0, 1, 8};
    localparam cfg_t C1 = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 4, 8};
    localparam cfg_t C2 = '{8, 1, 2, 1, 4, 1, 1, 1, 1, 1, 3, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    always #5 clk = ~clk;

    logic pe0, hs0, vs0, de0, sof0, vb0, eol0;
    logic [9:0] x0, y0;
    logic [7:0] f0;
    logic pe1, hs1, vs1, de1, sof1, vb1, eol1;
    logic [9:0] x1, y1;
    logic [7:0] f1;
    logic pe2, hs2, vs2, de2, sof2, vb2, eol2;
    logic [3:0] x2, y2;
    logic [1:0] f2;

    video_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                       .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
                       .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .CW(10), .FW(8)) u_d0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe0), .hsync(hs0), .vsync(vs0), .de(de0),
        .xpos(x0), .ypos(y0), .sof(sof0), .vblank(vb0), .eol(eol0), .frame_cnt(f0));

    video_timing_gen #(.CLK_DIV(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe1), .hsync(hs1), .vsync(vs1), .de(de1),
        .xpos(x1), .ypos(y1), .sof(sof1), .vblank(vb1), .eol(eol1), .frame_cnt(f1));

    video_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                       .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(3), .CW(4), .FW(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe2), .hsync(hs2), .vsync(vs2), .de(de2),
        .xpos(x2), .ypos(y2), .sof(sof2), .vblank(vb2), .eol(eol2), .frame_cnt(f2));

    out_t a0, a1, a2;
    assign a0 = {pe0, hs0, vs0, de0, sof0, vb0, eol0, 16'(x0), 16'(y0), 8'(f0)};
    assign a1 = {pe1, hs1, vs1, de1, sof1, vb1, eol1, 16'(x1), 16'(y1), 8'(f1)};
    assign a2 = {pe2, hs2, vs2, de2, sof2, vb2, eol2, 16'(x2), 16'(y2), 8'(f2)};

    // Raster position derived from the number of clocks since reset release.
    function automatic out_t model(input int kk, input cfg_t c);
        out_t o;
        int ht, vt, l, p, x, y;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        o = '0;
        o.pix_en = ((kk % c.dv) == c.dv - 1);
        l = kk / c.dv;
        if (l == 0) begin
            o.hsync = (c.hp == 0);
            o.vsync = (c.vp == 0);
        end else begin
            p = l - 1;
            x = p % ht;
            y = (p / ht) % vt;
            o.x = 16'(x);
            o.y = 16'(y);
            o.hsync  = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? (c.hp != 0) : (c.hp == 0);
            o.vsync  = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? (c.vp != 0) : (c.vp == 0);
            o.de     = (x < c.ha) && (y < c.va);
            o.sof    = (x == 0) && (y == 0);
            o.vblank = (x == 0) && (y == c.va);
            o.eol    = (x == ht - 1);
            o.frame  = 8'((l / (ht * vt)) % (1 << c.fw));
        end
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    always @(negedge clk) begin
        chk_out("cyc_d0", a0, model(k, C0));
        chk_out("cyc_d1", a1, model(k, C1));
        chk_out("cyc_d2", a2, model(k, C2));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_off();
        int o;
        o = int'($urandom_range(2, 7));
        if (o >= 5) o++;
        return o;
    endfunction

    task automatic chk_reset_all(input string name);
        chk_out({name, "_d0"}, a0, model(0, C0));
        chk_out({name, "_d1"}, a1, model(0, C1));
        chk_out({name, "_d2"}, a2, model(0, C2));
    endtask

    vec_t tbl[$];

    initial begin
        int n, cnt, found, prev;

        tbl.push_back('{0,  0, 6'b001100});
        tbl.push_back('{7,  3, 6'b001000});
        tbl.push_back('{8,  3, 6'b000000});
        tbl.push_back('{11, 3, 6'b000001});
        tbl.push_back('{0,  4, 6'b000010});
        tbl.push_back('{9,  4, 6'b100000});
        tbl.push_back('{3,  5, 6'b010000});
        tbl.push_back('{10, 5, 6'b110000});
        tbl.push_back('{0,  6, 6'b000000});
        tbl.push_back('{11, 6, 6'b000001});

        repeat (3) @(posedge clk);
        #2;
        chk_reset_all("in_reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step();
            if (sof1) n = i;
        end
        chk("d1_first_sof_clks", n, 4);

        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pe1) cnt++;
        end
        chk("d1_pix_en_per_40", cnt, 10);

        foreach (tbl[t]) begin
            found = 0;
            for (int i = 0; i < 400 && found == 0; i++) begin
                step();
                if (int'(x2) == tbl[t].x && int'(y2) == tbl[t].y) found = 1;
            end
            chk($sformatf("d2_reach_%0d_%0d", tbl[t].x, tbl[t].y), found, 1);
            chk($sformatf("d2_dec_%0d_%0d", tbl[t].x, tbl[t].y),
                int'({hs2, vs2, de2, sof2, vb2, eol2}), int'(tbl[t].exp));
        end

        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            if (sof2) found = 1;
        end
        chk("d2_sof_seen", found, 1);
        cnt = 0;
        for (int i = 0; i < 84 * 3; i++) begin
            if (de2) cnt++;
            step();
        end
        chk("d2_de_clks_per_frame", cnt, 32 * 3);

        found = 0;
        for (int i = 0; i < 1500 && found == 0; i++) begin
            step();
            if (f2 == 2'd3) found = 1;
        end
        chk("d2_frame_reach_3", found, 1);
        prev = int'(f2);
        for (int i = 0; i < 400 && int'(f2) == prev; i++) step();
        chk("d2_frame_wrap", int'(f2), 0);

        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            step();
            if (!hs0) found = 1;
        end
        chk("d0_hsync_seen", found, 1);
        chk("d0_hsync_start_x", int'(x0), 656);
        cnt = 0;
        while (!hs0 && cnt < 200) begin
            cnt++;
            step();
        end
        chk("d0_hsync_clks", cnt, 96);

        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            step();
            if (eol0) found = 1;
        end
        chk("d0_eol_seen", found, 1);
        chk("d0_eol_x", int'(x0), 799);
        step();
        cnt = 1;
        while (!eol0 && cnt < 2000) begin
            cnt++;
            step();
        end
        chk("d0_line_clks", cnt, 800);

        found = 0;
        for (int i = 0; i < 12000 && found == 0; i++) begin
            step();
            if (!vs0) found = 1;
        end
        chk("d0_vsync_seen", found, 1);
        chk("d0_vsync_start_y", int'(y0), 8);
        chk("d0_vsync_start_x", int'(x0), 0);
        cnt = 0;
        while (!vs0 && cnt < 3000) begin
            cnt++;
            step();
        end
        chk("d0_vsync_clks", cnt, 1600);

        found = 0;
        for (int i = 0; i < 12000 && found == 0; i++) begin
            step();
            if (sof0) found = 1;
        end
        chk("d0_sof_seen", found, 1);
        step();
        cnt = 1;
        while (!sof0 && cnt < 12000) begin
            cnt++;
            step();
        end
        chk("d0_sof_period", cnt, 9600);

        found = 0;
        for (int i = 0; i < 12000 && found == 0; i++) begin
            step();
            if (int'(y0) == 5 && !hs0) found = 1;
        end
        chk("d0_line5_hsync_seen", found, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_all("midsync_reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("restart_sof", int'(sof0), 1);
        chk("restart_xy", int'({x0, y0}), 0);
        chk("restart_de", int'(de0), 1);

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(20, 1500)) @(posedge clk);
            #(rand_off()) rst_n = 1'b0;
            #1;
            chk_reset_all($sformatf("rand_reset_%0d", r));
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #(rand_off()) rst_n = 1'b1;
        end

        repeat (300) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
